// File: rtl/arb_pkg.sv
// Shared definitions for the 16-requester round-robin arbiter.
//   N, IDX_W  : requester count and encoded index width
//   MAX_HOLD  : grant cycles an owner may hold before a forced hand-over
//               (only used when ARB_TIMEOUT_EN is defined)
//   state_t   : arbiter FSM states
//   rotr16    : rotate a 16-bit vector right by 0..15 positions
package arb_pkg;

  localparam int N        = 16;
  localparam int IDX_W    = 4;
  localparam int MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N-1:0] rotr16(input logic [N-1:0] v,
                                          input logic [IDX_W-1:0] s);
    logic [2*N-1:0] dbl;
    dbl = {v, v} >> s;
    return dbl[N-1:0];
  endfunction

endpackage

// File: rtl/prio_enc_16to4.sv
// Combinational 16-to-4 priority encoder, lowest index wins.
//   in  [15:0] : request vector
//   idx [3:0]  : index of the lowest set bit (0 when none set)
//   vld        : any bit of in is set
module prio_enc_16to4
  import arb_pkg::*;
(
  input  logic [N-1:0]     in,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter sharing one resource among 16 requesters.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   req      : request vector, bit i = requester i
//   gnt      : registered one-hot grant
//   gnt_idx  : registered index of the owner (holds last value when idle)
//   gnt_vld  : high while any grant is active
// Optional macro ARB_TIMEOUT_EN: forces an owner to hand over after
// MAX_HOLD consecutive grant cycles when another requester is waiting.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; search req starting at ptr
// GRANT | owner gnt_idx holds the resource until it drops its request
module rr_arbiter_16
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [N-1:0]     gnt_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             vld_nxt;

  logic             owner_req;
  logic             release_now;
  logic             force_rel;
  logic [IDX_W-1:0] ptr_after;
  logic [IDX_W-1:0] search_base;
  logic [N-1:0]     search_req;
  logic [N-1:0]     rot_req;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_vld;
  logic [IDX_W-1:0] win_idx;

`ifdef ARB_TIMEOUT_EN
  logic [IDX_W-1:0] hold_cnt;
  logic             new_grant;
`endif

  // gnt is one-hot while in GRANT, so this picks out req[owner].
  assign owner_req = |(req & gnt);
  assign ptr_after = gnt_idx + 1'b1;

`ifdef ARB_TIMEOUT_EN
  assign force_rel = (state == GRANT) && owner_req &&
                     (hold_cnt == IDX_W'(MAX_HOLD - 1)) && |(req & ~gnt);
`else
  assign force_rel = 1'b0;
`endif

  assign release_now = (state == GRANT) && (!owner_req || force_rel);

  // On release the search restarts just past the owner and excludes it;
  // from IDLE it starts at the stored pointer.
  assign search_base = (state == GRANT) ? ptr_after : ptr;
  assign search_req  = (state == GRANT) ? (req & ~gnt) : req;
  assign rot_req     = rotr16(search_req, search_base);

  prio_enc_16to4 u_prio_enc (
    .in  (rot_req),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  // 4-bit add wraps modulo 16, undoing the rotation.
  assign win_idx = enc_idx + search_base;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    idx_nxt   = gnt_idx;
    vld_nxt   = gnt_vld;
`ifdef ARB_TIMEOUT_EN
    new_grant = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (enc_vld) begin
          gnt_nxt   = N'(1) << win_idx;
          idx_nxt   = win_idx;
          vld_nxt   = 1'b1;
          state_nxt = GRANT;
`ifdef ARB_TIMEOUT_EN
          new_grant = 1'b1;
`endif
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_nxt = ptr_after;
          if (enc_vld) begin
            gnt_nxt = N'(1) << win_idx;
            idx_nxt = win_idx;
            vld_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
            new_grant = 1'b1;
`endif
          end else begin
            gnt_nxt   = '0;
            vld_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      gnt_idx <= idx_nxt;
      gnt_vld <= vld_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Counts cycles of the current ownership; saturates so a waiting
  // requester triggers the hand-over as soon as it appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (new_grant || state_nxt == IDLE) begin
      hold_cnt <= '0;
    end else if (state == GRANT && hold_cnt != IDX_W'(MAX_HOLD - 1)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: directed scenarios plus
// randomized request traffic against a behavioural round-robin model.
module tb_rr_arbiter_16;

  localparam int TB_MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_vld;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: owner = -1 when nobody holds the grant
  int m_owner;
  int m_ptr;
  int m_idx;
  int m_hold;

  always #5 clk = ~clk;

  rr_arbiter_16 dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int search(input logic [15:0] r, input int start);
    for (int i = 0; i < 16; i++) begin
      int j;
      j = (start + i) % 16;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [15:0] q);
    int w;
    logic [15:0] masked;
    bit hand_over;
    if (r) begin
      m_owner = -1; m_idx = 0; m_ptr = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      w = search(q, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_idx = w; m_hold = 0;
      end
    end else begin
      hand_over = !q[m_owner];
`ifdef ARB_TIMEOUT_EN
      masked = q;
      masked[m_owner] = 1'b0;
      if (q[m_owner] && m_hold == TB_MAX_HOLD - 1 && masked != 0)
        hand_over = 1;
`endif
      if (hand_over) begin
        m_ptr = (m_owner + 1) % 16;
        masked = q;
        masked[m_owner] = 1'b0;
        w = search(masked, m_ptr);
        m_hold = 0;
        if (w >= 0) begin
          m_owner = w; m_idx = w;
        end else begin
          m_owner = -1;
        end
      end else if (m_hold < TB_MAX_HOLD - 1) begin
        m_hold++;
      end
    end
  endtask

  // Apply inputs for one cycle, advance the model, compare after the edge.
  task automatic step(input logic r, input logic [15:0] q);
    logic [15:0] exp_gnt;
    rst = r;
    req = q;
    model_step(r, q);
    @(posedge clk);
    #1;
    exp_gnt = (m_owner < 0) ? 16'h0 : (16'h1 << m_owner);
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("gnt_vld", 32'(gnt_vld), 32'(m_owner >= 0));
    check("gnt_idx", 32'(gnt_idx), 32'(m_idx));
  endtask

  initial begin
    int cur;
    int mode;
    logic [15:0] q;

    rst = 1'b1;
    req = 16'h0;
    m_owner = -1; m_idx = 0; m_ptr = 0; m_hold = 0;

    // 1: reset holds everything low even with all requests up
    step(1'b1, 16'hFFFF);
    check("t1_gnt_rst", 32'(gnt), 32'h0);
    step(1'b1, 16'hFFFF);
    check("t1_vld_rst", 32'(gnt_vld), 32'h0);
    check("t1_idx_rst", 32'(gnt_idx), 32'h0);
    step(1'b0, 16'hFFFF);
    check("t1_gnt", 32'(gnt), 32'h0001);
    check("t1_idx", 32'(gnt_idx), 32'h0);

    // 2: single requester, then release to idle
    step(1'b1, 16'h0);
    step(1'b0, 16'h0010);
    check("t2_gnt", 32'(gnt), 32'h0010);
    check("t2_idx", 32'(gnt_idx), 32'd4);
    step(1'b0, 16'h0);
    check("t2_gnt_off", 32'(gnt), 32'h0);
    check("t2_vld_off", 32'(gnt_vld), 32'h0);
    check("t2_idx_hold", 32'(gnt_idx), 32'd4);
    // re-request after passing through idle
    step(1'b0, 16'h0010);
    check("t2_regrant", 32'(gnt), 32'h0010);

    // 3: full rotation with each owner dropping for one cycle
    step(1'b1, 16'h0);
    step(1'b0, 16'hFFFF);
    check("t3_first", 32'(gnt_idx), 32'd0);
    cur = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 16'hFFFF & ~(16'h1 << cur));
      check("t3_seq", 32'(gnt_idx), 32'((cur + 1) % 16));
      check("t3_vld", 32'(gnt_vld), 32'h1);
      cur = (cur + 1) % 16;
    end

    // 4: owner 3 releases, search wraps from 4 to 0 without a bubble
    step(1'b1, 16'h0);
    step(1'b0, 16'h0008);
    check("t4_own3", 32'(gnt_idx), 32'd3);
    step(1'b0, 16'h0009);
    check("t4_hold", 32'(gnt_idx), 32'd3);
    step(1'b0, 16'h0001);
    check("t4_wrap", 32'(gnt_idx), 32'd0);
    check("t4_vld", 32'(gnt_vld), 32'h1);

    // 5: owner 15 releases, pointer wraps to 0, requester 1 wins over 14
    step(1'b1, 16'h0);
    step(1'b0, 16'h8000);
    check("t5_own15", 32'(gnt_idx), 32'd15);
    step(1'b0, 16'hC002);
    step(1'b0, 16'h4002);
    check("t5_wrap", 32'(gnt_idx), 32'd1);

    // 6: two constant requesters
    step(1'b1, 16'h0);
    step(1'b0, 16'h0003);
    check("t6_first", 32'(gnt_idx), 32'd0);
    for (int c = 1; c < 100; c++) begin
      step(1'b0, 16'h0003);
`ifdef ARB_TIMEOUT_EN
      check("t6_alt", 32'(gnt_idx), 32'((c / TB_MAX_HOLD) % 2));
`else
      check("t6_stay", 32'(gnt_idx), 32'd0);
`endif
    end

    // randomized traffic in short phases of differing character
    q = 16'h0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) mode = $urandom_range(0, 3);
      case (mode)
        0: q = 16'($urandom);
        1: q = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2: if ($urandom_range(0, 3) == 0) q[$urandom_range(0, 15)] ^= 1'b1;
        default: if (c % 64 == 0) q = 16'($urandom);
      endcase
      step($urandom_range(0, 199) == 0, q);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_16.md
Name: rr_arbiter_16

Overview:
- Round-robin arbiter that shares one downstream resource among 16 requesters.
- Its core is a 16-to-4 priority encoder, applied to rotated request vectors.
- Produces a registered one-hot grant, the 4-bit encoded grant index and a valid flag.
- Sits in front of any shared datapath in the encoder/decoder library, for example a shared decoder or bus port.

Parameters:
- N, 16, number of requesters; the design is fixed at 16.
- IDX_W, 4, width of the encoded index (log2 N).
- MAX_HOLD, 8, maximum consecutive grant cycles per owner; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  16  request vector; bit i is requester i.
- gnt  output  16  registered one-hot grant.
- gnt_idx  output  4  registered encoded index of the granted requester.
- gnt_vld  output  1  high while any grant is active.

Behaviour:
- Reset (rst=1 at a clk edge) clears gnt=0, gnt_idx=0, gnt_vld=0, ptr=0, hold_cnt=0 and state=IDLE. rst has priority over every other event.
- Reset mid-grant drops the grant at that same edge.
- State machine has two states: IDLE and GRANT.
- Arbitration search: starting at bit ptr, scan upward with wrap 15→0. The first set req bit wins.
- Implementation: rotate req right by ptr, priority-encode (lowest bit wins), then add ptr modulo 16.
- IDLE:
  - req==0: stay in IDLE, outputs 0.
  - Any req set: at the next edge load gnt, gnt_idx and gnt_vld=1, then go to GRANT.
  - Latency from request to grant is 1 cycle.
- GRANT, with the owner at index k:
  - req[k]==1: hold the grant. Changes on other req bits are ignored.
  - req[k]==0 (release): set ptr=k+1 (15 wraps to 0) and search req with bit k masked.
  - Release with a winner found: grant it at that same edge, so there is no idle bubble between owners.
  - Release with no winner: gnt=0, gnt_vld=0, go to IDLE. gnt_idx holds its last value.
- gnt is always one-hot or zero. gnt_vld equals |gnt. gnt_idx is valid only while gnt_vld=1.
- A single requester that releases and re-requests is re-granted after passing through IDLE: 1 cycle with grant low.
- All 16 requests asserted with each releasing after 1 cycle gives a grant order 0,1,2,…,15,0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt (4-bit) increments every GRANT cycle and clears on every new grant.
  - When hold_cnt==MAX_HOLD-1, req[k] is still 1 and another req bit is set, the arbiter forces a release: ptr=k+1 and the next winner is granted at that edge.
  - If no other request is pending, the owner keeps the grant and hold_cnt saturates.
- Undefined: no hold_cnt register exists and the owner holds the grant indefinitely.

Decomposition:
- Package arb_pkg holds:
  - localparams N=16 and IDX_W=4.
  - The state enum with IDLE=1'b0 and GRANT=1'b1.
  - A rotate-right function for 16-bit vectors.
- Sub-module prio_enc_16to4: combinational 16-to-4 lowest-index-first priority encoder with an any-valid output. It is instantiated once in the arbitration path.

Test Plan:
1. rst=1 for 2 cycles with req=16'hFFFF → gnt=0, gnt_vld=0, gnt_idx=0 throughout. After rst falls, gnt=16'h0001 and gnt_idx=0 one cycle later.
2. req=16'h0010 from IDLE → next cycle gnt=16'h0010, gnt_idx=4. Drop req → next cycle gnt=0, gnt_vld=0.
3. req=16'hFFFF, each owner drops its bit for 1 cycle after being granted → gnt_idx sequence 0,1,…,15,0 with gnt_vld continuously high.
4. Owner 3 granted, req=16'h0009, owner releases → next edge gnt_idx=0 (wrap search from ptr=4), with no bubble.
5. Owner 15 granted while req[1] and req[14] are set, owner releases → gnt_idx=1 (ptr wrapped to 0).
6. With ARB_TIMEOUT_EN and MAX_HOLD=8, req=16'h0003 held constant → grant alternates 0 and 1 every 8 cycles. Without the macro, gnt_idx stays 0 for 100 cycles.
